// File: rtl/dstream_pkg.sv
// Shared definitions for the dstream data-stream fabric: default widths,
// pointer sizing and the elaboration-time parameter check for stream FIFOs.

`ifndef DSTREAM_PKG_SV
`define DSTREAM_PKG_SV

package dstream_pkg;

  // Defaults shared by every stream block so the fabric agrees on one width.
  localparam int DSTREAM_N_DEFAULT     = 16;
  localparam int DSTREAM_DEPTH_DEFAULT = 8;

  // Pointer width: one index bit per power of two plus a wrap bit, so that
  // full and empty remain distinguishable when the index bits are equal.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // DEPTH must be a power of two and at least 2, and the almost-full
  // threshold must be reachable by the occupancy count (1..DEPTH).
  function automatic bit fifo_params_ok(input int depth, input int thresh);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (thresh >= 1) && (thresh <= depth);
  endfunction

endpackage

// Expands to a generate-time check; use inside a module body.
`define DSTREAM_CHECK_PARAMS(depth, thresh) \
  if (!dstream_pkg::fifo_params_ok(depth, thresh)) begin : g_bad_params \
    $error("dstream: illegal DEPTH/AFULL_THRESH combination"); \
  end

`endif

// File: rtl/dstream_if.sv
// Valid/ready stream link. The producer drives valid and data, the consumer
// drives ready; a word moves on every rising edge where both are high.

interface dstream #(
  parameter int N = dstream_pkg::DSTREAM_N_DEFAULT
) ();

  logic         valid;
  logic         ready;
  logic [N-1:0] data;

  // Consumer-side view (the block receiving words).
  modport in  (input valid, input data, output ready);
  // Producer-side view (the block sending words).
  modport out (output valid, output data, input ready);

endinterface

// File: rtl/dstream_fifo_mem.sv
// Simple dual-port storage for the stream FIFO: one synchronous write port,
// one asynchronous read port. Kept separate so it can be replaced by a
// block-RAM wrapper without touching the pointer logic.

module dstream_fifo_mem
  import dstream_pkg::*;
#(
  parameter int N     = DSTREAM_N_DEFAULT,
  parameter int DEPTH = DSTREAM_DEPTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [ptr_w(DEPTH)-2:0]   waddr,
  input  logic [N-1:0]              wdata,
  input  logic [ptr_w(DEPTH)-2:0]   raddr,
  output logic [N-1:0]              rdata
);

  logic [N-1:0] mem_q [DEPTH];

  // Write port: capture the pushed word at the write index.
  // NOTE: storage has no reset; stale words are never visible because the
  // pointers decide what is valid, and a reset here would block RAM inference.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port is combinational so the head word falls through to the output.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dstream_fifo.sv
// First-word-fall-through FIFO between two dstream links, with occupancy
// count, almost-full flag and synchronous flush. Storage lives in
// dstream_fifo_mem; pointers, flags and handshakes are handled here.

module dstream_fifo
  import dstream_pkg::*;
#(
  parameter int N            = DSTREAM_N_DEFAULT,
  parameter int DEPTH        = DSTREAM_DEPTH_DEFAULT,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  dstream.in                       x,
  dstream.out                      y,
  output logic [ptr_w(DEPTH)-1:0]  level,
  output logic                     almost_full
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW-1:0] AFULL_L = PW'(AFULL_THRESH);

  `DSTREAM_CHECK_PARAMS(DEPTH, AFULL_THRESH)

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] level_q,  level_d;

  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic [N-1:0]  mem_rdata;

  // Occupancy flags from the wrap-bit pointer scheme.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // Ready depends only on state, flush and reset, never on x.valid or
  // y.ready, so no combinational path runs through the block. Including
  // rst_n makes ready drop the moment reset is asserted.
  assign x.ready = !full && !flush && rst_n;
  assign y.valid = !empty && !flush;
  assign y.data  = mem_rdata;

  assign push = x.valid && x.ready;
  assign pop  = y.valid && y.ready;

  // Next-state for pointers and level; flush overrides both handshakes.
  // NOTE: every output of this block gets a default first so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    level_d = wr_ptr_d - rd_ptr_d;
  end

  // State registers; level is registered alongside the pointers.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign level       = level_q;
  // Derived from the registered level only, so it never glitches with inputs.
  assign almost_full = (level_q >= AFULL_L);

  dstream_fifo_mem #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (x.data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (mem_rdata)
  );

`ifndef SYNTHESIS
  // Internal consistency: level always equals the pointer distance and
  // never exceeds the capacity; nothing is written while full.
  a_level_matches : assert property (@(posedge clk) disable iff (!rst_n)
    level_q == PW'(wr_ptr_q - rd_ptr_q));
  a_level_bound : assert property (@(posedge clk) disable iff (!rst_n)
    level_q <= PW'(DEPTH));
  a_no_push_full : assert property (@(posedge clk) disable iff (!rst_n)
    full |-> !push);
`endif

endmodule

// File: tb/tb_dstream_fifo.sv
// Self-checking bench for dstream_fifo: a queue model of the FIFO is
// compared against the DUT every cycle, plus directed literal checks.

module tb_dstream_fifo;

  localparam int N      = 16;
  localparam int DEPTH  = 8;
  localparam int THRESH = DEPTH - 2;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [LW-1:0] level;
  logic          almost_full;

  logic          flush2 = 1'b0;
  logic [1:0]    level2;
  logic          almost_full2;

  dstream #(.N(N)) x_if ();
  dstream #(.N(N)) y_if ();
  dstream #(.N(N)) x2_if ();
  dstream #(.N(N)) y2_if ();

  int n_pass  = 0;
  int n_total = 0;

  logic [N-1:0] mq [$];

  always #5 clk = ~clk;

  dstream_fifo #(.N(N), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .x           (x_if),
    .y           (y_if),
    .level       (level),
    .almost_full (almost_full)
  );

  dstream_fifo #(.N(N), .DEPTH(2), .AFULL_THRESH(1)) dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush2),
    .x           (x2_if),
    .y           (y2_if),
    .level       (level2),
    .almost_full (almost_full2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: an ordered queue of at most DEPTH words.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else begin
      automatic bit do_pop  = (mq.size() != 0) && y_if.ready;
      automatic bit do_push = x_if.valid && (mq.size() < DEPTH);
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(x_if.data);
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    automatic int  sz     = mq.size();
    automatic bit  exp_yv = (sz != 0) && !flush;
    automatic bit  exp_xr = rst_n && !flush && (sz < DEPTH);
    check("m_x_ready", x_if.ready, exp_xr);
    check("m_y_valid", y_if.valid, exp_yv);
    check("m_level", level, sz);
    check("m_almost_full", almost_full, sz >= THRESH);
    if (exp_yv) check("m_y_data", y_if.data, mq[0]);
  end

  task automatic set_in(input logic xv, input logic [N-1:0] xd, input logic yr, input logic fl);
    x_if.valid = xv;
    x_if.data  = xd;
    y_if.ready = yr;
    flush      = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx, rx, cyc;
    bit xv, yr, acc, pp;

    set_in(1'b0, '0, 1'b0, 1'b0);
    x2_if.valid = 1'b0;
    x2_if.data  = '0;
    y2_if.ready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #2;
    check("rst_x_ready", x_if.ready, 0);
    check("rst_y_valid", y_if.valid, 0);
    check("rst_level", level, 0);
    check("rst_afull", almost_full, 0);
    rst_n = 1'b1;
    #1;
    check("rel_x_ready", x_if.ready, 1);
    tick();

    // DEPTH=2 instance: full after two pushes, threshold 1.
    x2_if.valid = 1'b1; x2_if.data = 16'h00A1;
    tick();
    check("d2_level1", level2, 1);
    check("d2_afull1", almost_full2, 1);
    check("d2_ready1", x2_if.ready, 1);
    x2_if.data = 16'h00A2;
    tick();
    check("d2_level2", level2, 2);
    check("d2_ready_full", x2_if.ready, 0);
    check("d2_head", y2_if.data, 16'h00A1);
    x2_if.valid = 1'b0; y2_if.ready = 1'b1;
    tick();
    check("d2_head2", y2_if.data, 16'h00A2);
    check("d2_level_pop", level2, 1);
    tick();
    check("d2_empty", y2_if.valid, 0);
    y2_if.ready = 1'b0;

    // 1. Fill with back-pressure.
    for (int k = 1; k <= DEPTH; k++) begin
      set_in(1'b1, N'(k), 1'b0, 1'b0);
      #1;
      check("fill_x_ready", x_if.ready, 1);
      tick();
      check("fill_level", level, k);
      check("fill_afull", almost_full, (k >= 6) ? 1 : 0);
    end
    set_in(1'b1, 16'h00FF, 1'b0, 1'b0);
    #1;
    check("full_x_ready", x_if.ready, 0);
    check("full_y_valid", y_if.valid, 1);
    check("full_head", y_if.data, 16'h0001);
    tick();
    check("full_level_hold", level, 8);
    check("full_head_hold", y_if.data, 16'h0001);

    // 2. Drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b0, '0, 1'b1, 1'b0);
      #1;
      check("drain_valid", y_if.valid, 1);
      check("drain_data", y_if.data, i + 1);
      tick();
    end
    check("drain_empty", y_if.valid, 0);
    check("drain_level", level, 0);

    // 3. Full with simultaneous push and pop.
    for (int k = 1; k <= DEPTH; k++) begin
      set_in(1'b1, N'(k), 1'b0, 1'b0);
      tick();
    end
    set_in(1'b1, 16'h0009, 1'b1, 1'b0);
    #1;
    check("pp_x_ready", x_if.ready, 0);
    tick();
    check("pp_level_after", level, 7);
    set_in(1'b1, 16'h0009, 1'b0, 1'b0);
    #1;
    check("pp_x_ready_next", x_if.ready, 1);
    tick();
    check("pp_level_refill", level, 8);
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b0, '0, 1'b1, 1'b0);
      #1;
      check("pp_drain", y_if.data, (i < 7) ? i + 2 : 9);
      tick();
    end

    // 4. Random streaming with wrap.
    tx = 0; rx = 0; cyc = 0;
    while (rx < 1000 && cyc < 20000) begin
      xv = (tx < 1000) && ($urandom_range(0, 1) == 1);
      yr = ($urandom_range(0, 1) == 1);
      set_in(xv, N'(tx), yr, 1'b0);
      #1;
      acc = xv && (mq.size() < DEPTH);
      pp  = (mq.size() != 0) && yr;
      if (pp) check("stream_order", y_if.data, N'(rx));
      tick();
      if (acc) tx++;
      if (pp)  rx++;
      cyc++;
    end
    check("stream_rx_count", rx, 1000);
    check("stream_tx_count", tx, 1000);
    check("stream_wraps", (rx / DEPTH >= 100) ? 1 : 0, 1);
    set_in(1'b0, '0, 1'b0, 1'b0);
    #1;
    check("stream_level_end", level, 0);

    // 5. Flush.
    for (int k = 0; k < 5; k++) begin
      set_in(1'b1, N'(16'h0050 + k), 1'b0, 1'b0);
      tick();
    end
    check("fl_level5", level, 5);
    set_in(1'b1, 16'h1234, 1'b0, 1'b1);
    #1;
    check("fl_x_ready", x_if.ready, 0);
    check("fl_y_valid", y_if.valid, 0);
    tick();
    set_in(1'b0, '0, 1'b0, 1'b0);
    #1;
    check("fl_level0", level, 0);
    check("fl_y_valid_after", y_if.valid, 0);
    check("fl_afull", almost_full, 0);
    set_in(1'b1, 16'hABCD, 1'b0, 1'b0);
    tick();
    set_in(1'b0, '0, 1'b0, 1'b0);
    #1;
    check("fl_abcd_valid", y_if.valid, 1);
    check("fl_abcd_data", y_if.data, 16'hABCD);
    check("fl_abcd_level", level, 1);
    set_in(1'b0, '0, 1'b1, 1'b0);
    tick();

    // 6. Asynchronous reset mid-burst.
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, N'(16'h0060 + k), 1'b0, 1'b0);
      tick();
    end
    check("ar_level3", level, 3);
    set_in(1'b1, 16'h7777, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_x_ready", x_if.ready, 0);
    check("ar_y_valid", y_if.valid, 0);
    check("ar_level", level, 0);
    check("ar_afull", almost_full, 0);
    tick();
    tick();
    #2;
    rst_n = 1'b1;
    #1;
    check("ar_rel_ready", x_if.ready, 1);
    check("ar_rel_level", level, 0);
    tick();
    set_in(1'b0, '0, 1'b0, 1'b0);
    #1;
    check("ar_new_level", level, 1);
    check("ar_new_data", y_if.data, 16'h7777);
    set_in(1'b0, '0, 1'b1, 1'b0);
    tick();
    set_in(1'b0, '0, 1'b0, 1'b0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
